// File: rtl/uart_pkg.sv
// Shared UART framing definitions: header byte, RX FIFO entry, framer states.
package uart_pkg;

  localparam logic [7:0] HEADER_BYTE = 8'h01;

  typedef struct packed {
    logic       cmd;
    logic [7:0] data;
  } rx_entry_t;

  typedef enum logic {
    FR_IDLE,
    FR_ESCAPE
  } framer_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through FIFO of rx_entry_t; head is zero when empty.
// A push while full is accepted only if a pop frees a slot the same cycle.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      push_i,
  input  rx_entry_t din_i,
  input  logic      pop_i,
  output rx_entry_t dout_o,
  output logic      full_o,
  output logic      empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  rx_entry_t   mem_q [DEPTH];
  rx_entry_t   mem_d [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  // Next storage and pointer values from accepted push/pop.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = din_i;
      wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  // Storage and pointer registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/uart_rx_cmd_framer.sv
// Unescapes the UART RX byte stream into data/command entries for the TAP.
// Optional: define UART_RX_ESCAPE_TIMEOUT_EN to abort a stalled escape.
module uart_rx_cmd_framer
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH          = 8,
  parameter logic [7:0]  HEADER         = HEADER_BYTE,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic       CLK_I,
  input  logic       RST_NI,
  input  logic       RX_VALID_I,
  input  logic [7:0] RX_DATA_I,
  input  logic       RX_ERROR_I,
  input  logic       READ_I,
  output logic [7:0] DATA_REC_O,
  output logic       CMD_REC_O,
  output logic       RX_EMPTY_O,
  output logic       OVERFLOW_O,
  output logic       ERROR_O,
  input  logic       CLEAR_I
);

  framer_state_e state_q, state_d;
  logic          overflow_q, overflow_d;
  logic          error_q, error_d;
  logic          push;
  rx_entry_t     push_entry;
  rx_entry_t     head;
  logic          fifo_full;
  logic          fifo_empty;
  logic          err_set;
  logic          ovf_set;

`ifdef UART_RX_ESCAPE_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
`endif

  // Escape decoding: chooses what to push and the next framer state.
  always_comb begin
    state_d    = state_q;
    push       = 1'b0;
    push_entry = '0;
    err_set    = 1'b0;
    if (RX_VALID_I) begin
      if (RX_ERROR_I) begin
        err_set = 1'b1;
        state_d = FR_IDLE;
      end else if (state_q == FR_IDLE) begin
        if (RX_DATA_I == HEADER) begin
          state_d = FR_ESCAPE;
        end else begin
          push       = 1'b1;
          push_entry = '{cmd: 1'b0, data: RX_DATA_I};
        end
      end else begin
        push       = 1'b1;
        push_entry = '{cmd: (RX_DATA_I != HEADER), data: RX_DATA_I};
        state_d    = FR_IDLE;
      end
    end
`ifdef UART_RX_ESCAPE_TIMEOUT_EN
    // Counter is zero whenever not in ESCAPE, so it starts cleared on entry;
    // an arriving byte always takes priority over the limit.
    tmo_cnt_d = '0;
    if (state_q == FR_ESCAPE && !RX_VALID_I) begin
      if (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
        err_set = 1'b1;
        state_d = FR_IDLE;
      end else begin
        tmo_cnt_d = tmo_cnt_q + TW'(1);
      end
    end
`endif
  end

  // Sticky flags: a set in the same cycle beats CLEAR_I.
  always_comb begin
    ovf_set    = push & fifo_full & ~READ_I;
    overflow_d = ovf_set ? 1'b1 : (CLEAR_I ? 1'b0 : overflow_q);
    error_d    = err_set ? 1'b1 : (CLEAR_I ? 1'b0 : error_q);
  end

  // Framer state and sticky flag registers.
  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      state_q    <= FR_IDLE;
      overflow_q <= 1'b0;
      error_q    <= 1'b0;
`ifdef UART_RX_ESCAPE_TIMEOUT_EN
      tmo_cnt_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      overflow_q <= overflow_d;
      error_q    <= error_d;
`ifdef UART_RX_ESCAPE_TIMEOUT_EN
      tmo_cnt_q  <= tmo_cnt_d;
`endif
    end
  end

  uart_rx_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (CLK_I),
    .rst_ni  (RST_NI),
    .push_i  (push),
    .din_i   (push_entry),
    .pop_i   (READ_I),
    .dout_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign DATA_REC_O = head.data;
  assign CMD_REC_O  = head.cmd;
  assign RX_EMPTY_O = fifo_empty;
  assign OVERFLOW_O = overflow_q;
  assign ERROR_O    = error_q;

endmodule

// File: tb/tb_uart_rx_cmd_framer.sv
// Randomized and directed bench for uart_rx_cmd_framer against a queue model.
module tb_uart_rx_cmd_framer;

  localparam int unsigned DEPTH = 8;
  localparam logic [7:0]  HDR   = 8'h01;
  localparam int unsigned TMO   = 16;

  logic       CLK_I = 1'b0;
  logic       RST_NI = 1'b0;
  logic       RX_VALID_I = 1'b0;
  logic [7:0] RX_DATA_I = '0;
  logic       RX_ERROR_I = 1'b0;
  logic       READ_I = 1'b0;
  logic       CLEAR_I = 1'b0;
  logic [7:0] DATA_REC_O;
  logic       CMD_REC_O;
  logic       RX_EMPTY_O;
  logic       OVERFLOW_O;
  logic       ERROR_O;

  uart_rx_cmd_framer #(
    .DEPTH          (DEPTH),
    .HEADER         (HDR),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .CLK_I      (CLK_I),
    .RST_NI     (RST_NI),
    .RX_VALID_I (RX_VALID_I),
    .RX_DATA_I  (RX_DATA_I),
    .RX_ERROR_I (RX_ERROR_I),
    .READ_I     (READ_I),
    .DATA_REC_O (DATA_REC_O),
    .CMD_REC_O  (CMD_REC_O),
    .RX_EMPTY_O (RX_EMPTY_O),
    .OVERFLOW_O (OVERFLOW_O),
    .ERROR_O    (ERROR_O),
    .CLEAR_I    (CLEAR_I)
  );

  always #5 CLK_I = ~CLK_I;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  // Reference model: a queue of {cmd,data} entries plus escape/sticky status.
  logic [8:0] mq[$];
  bit         m_esc;
  int         m_idle;
  bit         m_ovf;
  bit         m_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_esc  = 0;
    m_idle = 0;
    m_ovf  = 0;
    m_err  = 0;
  endtask

  task automatic model_step(input bit v, input logic [7:0] d, input bit e,
                            input bit r, input bit c);
    bit         ovf_s = 0;
    bit         err_s = 0;
    bit         psh   = 0;
    logic [8:0] ent   = '0;
    if (v) begin
      if (e) begin
        err_s = 1;
        m_esc = 0;
      end else if (!m_esc) begin
        if (d == HDR) begin
          m_esc  = 1;
          m_idle = 0;
        end else begin
          psh = 1;
          ent = {1'b0, d};
        end
      end else begin
        psh   = 1;
        ent   = {(d != HDR), d};
        m_esc = 0;
      end
    end
`ifdef UART_RX_ESCAPE_TIMEOUT_EN
    else if (m_esc) begin
      m_idle++;
      if (m_idle == TMO) begin
        m_esc = 0;
        err_s = 1;
      end
    end
`endif
    if (r && mq.size() > 0) void'(mq.pop_front());
    if (psh) begin
      if (mq.size() < DEPTH) mq.push_back(ent);
      else ovf_s = 1;
    end
    m_ovf = ovf_s ? 1'b1 : (c ? 1'b0 : m_ovf);
    m_err = err_s ? 1'b1 : (c ? 1'b0 : m_err);
  endtask

  task automatic check_outputs();
    logic [8:0] h;
    h = (mq.size() > 0) ? mq[0] : 9'h000;
    chk("rx_empty", RX_EMPTY_O, (mq.size() == 0));
    chk("data_rec", DATA_REC_O, h[7:0]);
    chk("cmd_rec",  CMD_REC_O,  h[8]);
    chk("overflow", OVERFLOW_O, m_ovf);
    chk("error",    ERROR_O,    m_err);
  endtask

  // One cycle: check state at the negedge, then drive this cycle's inputs.
  task automatic step(input bit v, input logic [7:0] d, input bit e,
                      input bit r, input bit c);
    @(negedge CLK_I);
    check_outputs();
    RX_VALID_I = v;
    RX_DATA_I  = d;
    RX_ERROR_I = e;
    READ_I     = r;
    CLEAR_I    = c;
    model_step(v, d, e, r, c);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 8'h00, 0, 0, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2; i++) step(0, 8'h00, 0, 1, 1);
    idle(1);
  endtask

  initial begin
    model_reset();
    #12;
    @(negedge CLK_I);
    chk("reset_empty", RX_EMPTY_O, 1);
    chk("reset_data",  DATA_REC_O, 0);
    chk("reset_cmd",   CMD_REC_O,  0);
    chk("reset_ovf",   OVERFLOW_O, 0);
    chk("reset_err",   ERROR_O,    0);
    RST_NI = 1'b1;

    // Two data bytes popped in order.
    step(1, 8'h12, 0, 0, 0);
    step(1, 8'h34, 0, 0, 0);
    idle(1);
    chk("first_head", DATA_REC_O, 8'h12);
    step(0, 8'h00, 0, 1, 0);
    step(0, 8'h00, 0, 1, 0);
    idle(1);
    chk("empty_after_pops", RX_EMPTY_O, 1);

    // Command byte after header.
    step(1, HDR, 0, 0, 0);
    step(1, 8'h21, 0, 0, 0);
    idle(1);
    chk("cmd_flag", CMD_REC_O, 1);
    chk("cmd_data", DATA_REC_O, 8'h21);
    drain();

    // Escaped literal header followed by a data byte.
    step(1, HDR, 0, 0, 0);
    step(1, HDR, 0, 0, 0);
    step(1, 8'h55, 0, 0, 0);
    idle(1);
    chk("literal_hdr", {CMD_REC_O, DATA_REC_O}, 9'h001);
    drain();

    // Overflow, push+pop at full, then clear.
    for (int i = 0; i < DEPTH + 1; i++) step(1, 8'h80 + 8'(i), 0, 0, 0);
    idle(1);
    chk("ovf_set", OVERFLOW_O, 1);
    chk("ovf_head", DATA_REC_O, 8'h80);
    step(1, 8'h99, 0, 1, 0);
    idle(1);
    chk("full_pushpop_head", DATA_REC_O, 8'h81);
    step(0, 8'h00, 0, 0, 1);
    idle(1);
    chk("ovf_cleared", OVERFLOW_O, 0);
    drain();

    // Error discards byte and pending escape.
    step(1, HDR, 0, 0, 0);
    step(1, 8'h40, 1, 0, 0);
    step(1, 8'h40, 0, 0, 0);
    idle(1);
    chk("err_set", ERROR_O, 1);
    chk("err_entry", {CMD_REC_O, DATA_REC_O}, 9'h040);
    drain();

    // Set beats clear in the same cycle.
    step(1, 8'h00, 1, 0, 1);
    idle(1);
    chk("set_beats_clear", ERROR_O, 1);
    drain();

`ifdef UART_RX_ESCAPE_TIMEOUT_EN
    step(1, HDR, 0, 0, 0);
    idle(TMO);
    step(1, 8'h21, 0, 0, 0);
    idle(1);
    chk("tmo_err", ERROR_O, 1);
    chk("tmo_entry", {CMD_REC_O, DATA_REC_O}, 9'h021);
    drain();
    // Byte arriving on the last allowed cycle still completes the escape.
    step(1, HDR, 0, 0, 0);
    idle(TMO - 1);
    step(1, 8'h22, 0, 0, 0);
    idle(1);
    chk("tmo_edge_err", ERROR_O, 0);
    chk("tmo_edge_entry", {CMD_REC_O, DATA_REC_O}, 9'h122);
    drain();
`endif

    // Async reset mid-stream with a pending escape.
    step(1, 8'h11, 0, 0, 0);
    step(1, HDR, 0, 0, 0);
    @(posedge CLK_I);
    #2;
    RST_NI     = 1'b0;
    RX_VALID_I = 1'b0;
    READ_I     = 1'b0;
    CLEAR_I    = 1'b0;
    #1;
    chk("arst_empty", RX_EMPTY_O, 1);
    chk("arst_data",  DATA_REC_O, 0);
    model_reset();
    @(negedge CLK_I);
    RST_NI = 1'b1;
    step(1, HDR, 0, 0, 0);
    step(1, 8'h21, 0, 0, 0);
    idle(1);
    chk("post_rst_cmd", {CMD_REC_O, DATA_REC_O}, 9'h121);
    drain();

    // Randomized traffic with bursty gaps.
    for (int i = 0; i < 4000; i++) begin
      bit         v;
      logic [7:0] d;
      v = ((i / 200) % 4 == 3) ? ($urandom_range(0, 40) == 0)
                               : ($urandom_range(0, 3) != 0);
      d = ($urandom_range(0, 3) == 0) ? HDR : 8'($urandom);
      step(v, d, ($urandom_range(0, 31) == 0), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 15) == 0));
    end
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
